// File: rtl/sbox_sched.sv
// sbox_sched: streams a two-share masked 16-bit S-AES state through one shared
// pipelined masked nibble S-box, one nibble per cycle, and reassembles the result.
module sbox_sched #(
  parameter int          SBOX_LAT  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  input  logic        seed_valid,
  input  logic [15:0] seed,
  output logic        busy,
  output logic [3:0]  sbox_a,
  output logic [3:0]  sbox_b,
  output logic [1:0]  sbox_z0,
  output logic [1:0]  sbox_z1,
  input  logic [3:0]  sbox_a_res,
  input  logic [3:0]  sbox_b_res
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;
  state_e      state_q, state_d;
  logic [15:0] sa_q, sa_d, sb_q, sb_d, ra_q, ra_d, rb_q, rb_d, lfsr_q, lfsr_d;
  logic [1:0]  feed_cnt_q, feed_cnt_d, col_cnt_q, col_cnt_d;
  logic [2:0]  tag_q [SBOX_LAT];
  logic        tag_v, feeding;
  logic [1:0]  tag_idx;
  logic [3:0]  fbase, tbase;
  assign feeding         = state_q == FEED;
  assign {tag_v, tag_idx} = tag_q[SBOX_LAT-1];
  // nibble 0 lives in the top bits, so the bit base is (3-idx)*4
  assign fbase     = {~feed_cnt_q, 2'b00};
  assign tbase     = {~tag_idx, 2'b00};
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign a_out     = ra_q;
  assign b_out     = rb_q;
  assign sbox_a    = feeding ? sa_q[fbase +: 4] : 4'h0;
  assign sbox_b    = feeding ? sb_q[fbase +: 4] : 4'h0;
  assign sbox_z0   = feeding ? lfsr_q[1:0] : 2'b00;
  assign sbox_z1   = feeding ? lfsr_q[3:2] : 2'b00;
  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    lfsr_d     = lfsr_q;
    feed_cnt_d = feed_cnt_q;
    col_cnt_d  = col_cnt_q;
    case (state_q)
      IDLE:
        if (in_valid) begin
          state_d    = FEED;
          sa_d       = a_in;
          sb_d       = b_in;
          feed_cnt_d = 2'd0;
          col_cnt_d  = 2'd0;
        end else if (seed_valid) lfsr_d = seed == 16'h0 ? LFSR_SEED : seed;
      FEED: begin
        feed_cnt_d = feed_cnt_q + 2'd1;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d    = feed_cnt_q == 2'd3 ? DRAIN : FEED;
      end
      DRAIN: state_d = tag_v && col_cnt_q == 2'd3 ? DONE : DRAIN;
      DONE:  state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (tag_v && (feeding || state_q == DRAIN)) begin
      ra_d[tbase +: 4] = sbox_a_res;
      rb_d[tbase +: 4] = sbox_b_res;
      col_cnt_d        = col_cnt_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      lfsr_q     <= LFSR_SEED;
      feed_cnt_q <= '0;
      col_cnt_q  <= '0;
      tag_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      lfsr_q     <= lfsr_d;
      feed_cnt_q <= feed_cnt_d;
      col_cnt_q  <= col_cnt_d;
      tag_q[0]   <= {feeding, feed_cnt_q};
      for (int i = 1; i < SBOX_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  a_tag_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    tag_v |-> (state_q == FEED || state_q == DRAIN));
endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: directed checks of sbox_sched against a behavioural masked S-AES S-box
// at latencies 3 (main), 1 and 8.
module tb_sbox_sched;
  logic clk, rst_n, in_valid, iv1, iv8, out_ready, seed_valid;
  logic [15:0] a_in, b_in, seed;
  logic ir3, ov3, busy3, ir1, ov1, busy1, ir8, ov8, busy8;
  logic [15:0] ao3, bo3, ao1, bo1, ao8, bo8;
  logic [3:0] sa3, sb3, ar3, br3, sa1, sb1, ar1, br1, sa8, sb8, ar8, br8;
  logic [1:0] z03, z13, z01, z11, z08, z18;
  logic [11:0] p3 [3];
  logic [11:0] p1 [1];
  logic [11:0] p8 [8];
  int checks = 0, failures = 0;

  sbox_sched #(.SBOX_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .a_in(a_in), .b_in(b_in), .out_valid(ov3), .out_ready(out_ready), .a_out(ao3), .b_out(bo3),
    .seed_valid(seed_valid), .seed(seed), .busy(busy3), .sbox_a(sa3), .sbox_b(sb3),
    .sbox_z0(z03), .sbox_z1(z13), .sbox_a_res(ar3), .sbox_b_res(br3));
  sbox_sched #(.SBOX_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a_in(a_in), .b_in(b_in), .out_valid(ov1), .out_ready(1'b1), .a_out(ao1), .b_out(bo1),
    .seed_valid(1'b0), .seed(16'h0), .busy(busy1), .sbox_a(sa1), .sbox_b(sb1),
    .sbox_z0(z01), .sbox_z1(z11), .sbox_a_res(ar1), .sbox_b_res(br1));
  sbox_sched #(.SBOX_LAT(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a_in(a_in), .b_in(b_in), .out_valid(ov8), .out_ready(1'b1), .a_out(ao8), .b_out(bo8),
    .seed_valid(1'b0), .seed(16'h0), .busy(busy8), .sbox_a(sa8), .sbox_b(sb8),
    .sbox_z0(z08), .sbox_z1(z18), .sbox_a_res(ar8), .sbox_b_res(br8));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sbx(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h94ABD1856203CEF7;
    return t[4*(15-int'(x)) +: 4];
  endfunction

  // masked S-box model: share B carries the mask {z1,z0}, share A the masked S(x)
  always @(posedge clk) begin
    p3[0] <= {4'h0, sbx(sa3 ^ sb3) ^ {z13, z03}, {z13, z03}};
    for (int i = 1; i < 3; i++) p3[i] <= p3[i-1];
    p1[0] <= {4'h0, sbx(sa1 ^ sb1) ^ {z11, z01}, {z11, z01}};
    p8[0] <= {4'h0, sbx(sa8 ^ sb8) ^ {z18, z08}, {z18, z08}};
    for (int j = 1; j < 8; j++) p8[j] <= p8[j-1];
  end
  assign {ar3, br3} = p3[2][7:0];
  assign {ar1, br1} = p1[0][7:0];
  assign {ar8, br8} = p8[7][7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start3(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    a_in = a;
    b_in = b;
    in_valid = 1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      in_valid = 0;
      lat++;
      if (ov3) break;
    end
  endtask

  task automatic wait_ov3();
    for (int i = 0; i < 40 && !ov3; i++) @(negedge clk);
  endtask

  initial begin
    int lat, bad, l1, l8;
    logic [15:0] ha, hb, r1, r8, zexp, av;
    rst_n = 0; in_valid = 0; iv1 = 0; iv8 = 0; out_ready = 0;
    seed_valid = 0; seed = 0; a_in = 0; b_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir3, 1);
    chk("rst_out_valid", ov3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_outs", {ao3, bo3}, 0);
    chk("rst_sbox", {sa3, sb3, z13, z03}, 0);
    chk("rst_lfsr", u3.lfsr_q, 16'hACE1);
    rst_n = 1;
    // basic state under back-pressure
    start3(16'h5A5A, 16'h5B79, lat);
    chk("lat3", lat, 8);
    chk("basic_xor", ao3 ^ bo3, 16'h94AB);
    ha = ao3;
    hb = bo3;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1;
      a_in = 16'($urandom);
      if (!(ao3 === ha && bo3 === hb && ov3 === 1'b1 && ir3 === 1'b0 && busy3 === 1'b1)) bad++;
    end
    chk("bp_stable", bad, 0);
    @(negedge clk);
    out_ready = 1;
    @(negedge clk);
    chk("hs_out_valid_drop", ov3, 0);
    chk("hs_no_same_cycle_accept", {ir3, busy3}, 2'b10);
    in_valid = 0;
    // randomness from a known seed
    @(negedge clk);
    seed_valid = 1;
    seed = 16'h0001;
    @(negedge clk);
    seed_valid = 0;
    chk("reseed_1", u3.lfsr_q, 16'h0001);
    a_in = 16'h1234;
    b_in = 16'h0000;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    zexp = 16'h8421;
    av = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("feed_z", {z13, z03}, zexp[4*k +: 4]);
      chk("feed_a", sa3, av[4*(3-k) +: 4]);
    end
    @(negedge clk);
    chk("drain_sbox_zero", {sa3, sb3, z13, z03}, 0);
    chk("drain_lfsr", u3.lfsr_q, 16'h0010);
    wait_ov3();
    chk("rand_done", ov3, 1);
    chk("done_lfsr", u3.lfsr_q, 16'h0010);
    chk("rand_xor", ao3 ^ bo3, 16'h4ABD);
    @(negedge clk);
    seed_valid = 1;
    seed = 16'h0000;
    @(negedge clk);
    seed_valid = 0;
    chk("reseed_zero", u3.lfsr_q, 16'hACE1);
    // accept wins over a simultaneous reseed
    in_valid = 1;
    seed_valid = 1;
    seed = 16'hBEEF;
    a_in = 16'h0000;
    b_in = 16'h0000;
    @(posedge clk);
    #1;
    in_valid = 0;
    seed_valid = 0;
    @(negedge clk);
    chk("sim_busy", busy3, 1);
    chk("sim_lfsr", u3.lfsr_q, 16'hACE1);
    chk("sim_z", {z13, z03}, 4'h1);
    wait_ov3();
    chk("sim_xor", ao3 ^ bo3, 16'h9999);
    @(negedge clk);
    // reset during feed cycle 2
    a_in = 16'h0123;
    b_in = 16'h0000;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mrst_state", {busy3, ir3, ov3}, 3'b010);
    chk("mrst_sbox", {sa3, sb3, z13, z03}, 0);
    chk("mrst_outs", {ao3, bo3}, 0);
    chk("mrst_lfsr", u3.lfsr_q, 16'hACE1);
    @(negedge clk);
    rst_n = 1;
    start3(16'hFFFF, 16'h0000, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_xor", ao3 ^ bo3, 16'h7777);
    // latency sweep
    @(negedge clk);
    a_in = 16'hABCD;
    b_in = 16'h0000;
    iv1 = 1;
    iv8 = 1;
    l1 = 0;
    l8 = 0;
    r1 = 0;
    r8 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      iv1 = 0;
      iv8 = 0;
      if (ov1 && l1 == 0) begin l1 = c; r1 = ao1 ^ bo1; end
      if (ov8 && l8 == 0) begin l8 = c; r8 = ao8 ^ bo8; end
      if (l1 != 0 && l8 != 0) break;
    end
    chk("lat1", l1, 6);
    chk("lat8", l8, 13);
    chk("res1", r1, 16'h03CE);
    chk("res8", r8, 16'h03CE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Controller that runs a full 16-bit two-share masked S-AES state through the single shared, pipelined masked nibble S-box: one nibble per cycle.
- Generates fresh per-nibble mask randomness (Z0/Z1) from an internal LFSR.
- Tags each nibble in flight and reassembles the four output nibbles into the substituted state.
- Sits between the round controller (SubNibbles step) and the masked S-box instance.

Parameters:
- SBOX_LAT, 3, S-box latency in cycles: input presented in cycle t → output valid in cycle t+SBOX_LAT (range 1..8).
- LFSR_SEED, 16'hACE1, LFSR reset value; also substituted for any zero reseed value.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  state shares on a_in/b_in are valid
- in_ready  out  1  block can accept a state
- a_in  in  16  share A of input state; nibble0 = [15:12] … nibble3 = [3:0]
- b_in  in  16  share B of input state
- out_valid  out  1  substituted shares valid
- out_ready  in  1  consumer accepts result
- a_out  out  16  share A of result
- b_out  out  16  share B of result
- seed_valid  in  1  reseed request
- seed  in  16  reseed value
- busy  out  1  high in any state except IDLE
- sbox_a  out  4  S-box share A input
- sbox_b  out  4  S-box share B input
- sbox_z0  out  2  S-box randomness Z0
- sbox_z1  out  2  S-box randomness Z1
- sbox_a_res  in  4  S-box share A output
- sbox_b_res  in  4  S-box share B output

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; in_ready=1, out_valid=0, busy=0.
  - a_out=b_out=0; sbox_a/b/z0/z1=0.
  - LFSR=LFSR_SEED; tag pipe cleared; all counters 0.
  - Reset mid-operation discards everything in flight; no partial result is ever presented.
- FSM: IDLE → FEED → DRAIN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - in_valid & in_ready at edge E0: capture a_in/b_in into share registers, feed_cnt=0, go FEED.
- FEED (exactly 4 cycles):
  - Cycle k (k=0..3) drives sbox_a/sbox_b = nibble k of the captured shares.
  - sbox_z0 = lfsr[1:0], sbox_z1 = lfsr[3:2].
  - LFSR steps once per FEED cycle, so every nibble gets distinct randomness.
  - A tag {valid, idx[1:0]} enters a SBOX_LAT-deep shift pipe.
  - After k=3, go DRAIN.
- DRAIN: sbox_a/b/z0/z1 forced to 0 (no stale share toggling).
- Collection (runs in FEED and DRAIN):
  - When the tag pipe output is valid, write sbox_a_res/sbox_b_res into nibble idx of the result registers and increment col_cnt.
  - When the 4th nibble is written, go DONE.
- DONE:
  - out_valid=1; a_out/b_out held stable until out_valid & out_ready.
  - On that handshake, go IDLE; out_valid drops the next cycle.
- Latency: out_valid asserts in cycle 5+SBOX_LAT after E0 (8 cycles for the default), independent of SBOX_LAT ordering effects.
- Throughput: one state per 6+SBOX_LAT cycles when out_ready is held high.
- in_ready=0 in all non-IDLE states; in_valid there is ignored.
- A new state cannot be accepted in the same cycle as the DONE handshake.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - Never zero.
  - Holds its value outside FEED.
- Reseed:
  - seed_valid is honoured only in IDLE, and only when in_valid is not also accepted that cycle.
  - When both occur in IDLE, acceptance wins and the reseed is dropped.
  - Loads seed, or LFSR_SEED if seed==0.
  - Ignored in other states.
- Result nibbles are written only by index, so out-of-order tag arrival is tolerated.
- A tag arriving outside FEED/DRAIN is impossible by construction; assert in simulation.

Test Plan:
- Basic state, behavioural S-box with S-AES table and SBOX_LAT=3: a_in=16'h5A5A, b_in=16'h5B79 (unmasked 16'h0123) → out_valid exactly 8 cycles after accept; a_out^b_out=16'h94AB.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → a_out/b_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle.
- Randomness: reseed 16'h0001, then run a state → four (z1,z0) pairs match the LFSR model steps 0..3; LFSR unchanged across DRAIN/DONE. Reseed with 0 → LFSR=16'hACE1.
- Reset mid-operation: assert rst_n=0 during FEED cycle 2 → all outputs at reset values immediately; next state 16'hFFFF^0 → a_out^b_out=16'h7777 with no stale nibbles.
- Latency sweep: SBOX_LAT=1 and 8 with state 16'hABCD (b=0) → result 16'h03CE; out_valid at cycle 6 and 13 respectively.
- Simultaneous in_valid and seed_valid in IDLE → state accepted, seed ignored, LFSR keeps its prior value.
